// File: rtl/rx_pkg.sv
// Shared types and widths for the USB receive packet controller.
package rx_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, RECV, ERR, EIDLE} rx_state_t;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned MAX_BYTES_DEF = 64;
    localparam int unsigned CNT_W         = $clog2(MAX_BYTES_DEF + 1);

endpackage

// File: rtl/rx_shift_reg.sv
// Right-shift register: new bit enters at the MSB, so the first bit received
// ends up in bit 0 after a full byte.
module rx_shift_reg
    import rx_pkg::*;
#(
    parameter int unsigned W = BYTE_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[W-1:1]};
        end
    end

endmodule

// File: rtl/rx_packet_ctrl.sv
// Receive packet controller: sync hunt, LSB-first byte assembly, FIFO writes, error flagging.
// Optional RX_BYTE_COUNT_EN adds the pkt_len output (bytes written in the last packet).
module rx_packet_ctrl
    import rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              d_edge,
    input  logic              shift_strobe,
    input  logic              rx_bit,
    input  logic              eop,
    input  logic              fifo_full,
    output logic              w_enable,
    output logic [BYTE_W-1:0] w_data,
    output logic              rcving,
    output logic              r_error
`ifdef RX_BYTE_COUNT_EN
    ,
    output logic [6:0]        pkt_len
`endif
);

    localparam int unsigned BC_W = $clog2(MAX_BYTES + 1);

    rx_state_t         state;
    logic [2:0]        bit_cnt;
    logic [BC_W-1:0]   byte_cnt;
    logic [BYTE_W-1:0] sr;
    logic [BYTE_W-1:0] sr_next;
    logic              active;
    logic              shift_en;
    logic              last_bit;
    logic              pkt_end;
    logic              pkt_start;

    // eop takes priority over a coincident strobe, so the strobe never shifts.
    assign active    = (state == SYNC) || (state == RECV);
    assign shift_en  = shift_strobe && !eop && active;
    assign last_bit  = shift_en && (bit_cnt == 3'd7);
    assign sr_next   = {rx_bit, sr[BYTE_W-1:1]};
    assign pkt_end   = eop && ((state == SYNC) || (state == RECV) || (state == ERR));
    assign pkt_start = d_edge && ((state == IDLE) || (state == EIDLE));

    rx_shift_reg #(.W(BYTE_W)) u_shift_reg (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (shift_en),
        .din   (rx_bit),
        .q     (sr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            w_enable <= 1'b0;
            w_data   <= '0;
            rcving   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            case (state)
                IDLE, EIDLE: begin
                    if (d_edge) begin
                        state    <= SYNC;
                        rcving   <= 1'b1;
                        r_error  <= 1'b0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                SYNC: begin
                    if (eop) begin
                        state   <= EIDLE;
                        rcving  <= 1'b0;
                        r_error <= 1'b1;
                    end else if (last_bit) begin
                        if (sr_next == SYNC_BYTE) begin
                            state <= RECV;
                        end else begin
                            state   <= ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (eop) begin
                        rcving <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            state <= IDLE;
                        end else begin
                            state   <= EIDLE;
                            r_error <= 1'b1;
                        end
                    end else if (last_bit) begin
                        // fifo_full is sampled with the completing strobe, the decision point for the write
                        if (fifo_full || (byte_cnt == BC_W'(MAX_BYTES))) begin
                            state   <= ERR;
                            r_error <= 1'b1;
                        end else begin
                            w_enable <= 1'b1;
                            w_data   <= sr_next;
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                ERR: begin
                    if (eop) begin
                        state  <= EIDLE;
                        rcving <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rcving <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_BYTE_COUNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_len <= '0;
        end else if (pkt_start) begin
            pkt_len <= '0;
        end else if (pkt_end) begin
            pkt_len <= 7'(byte_cnt);
        end
    end
`else
    logic unused_pkt;
    assign unused_pkt = pkt_start ^ pkt_end;
`endif

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed scoreboard bench for rx_packet_ctrl (MAX_BYTES=2 so overflow is reachable).
module tb_rx_packet_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       d_edge = 1'b0;
    logic       shift_strobe = 1'b0;
    logic       rx_bit = 1'b0;
    logic       eop = 1'b0;
    logic       fifo_full = 1'b0;
    logic       w_enable;
    logic [7:0] w_data;
    logic       rcving;
    logic       r_error;
`ifdef RX_BYTE_COUNT_EN
    logic [6:0] pkt_len;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic       prev_we = 1'b0;

    always #5 clk = ~clk;

    rx_packet_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .shift_strobe (shift_strobe),
        .rx_bit       (rx_bit),
        .eop          (eop),
        .fifo_full    (fifo_full),
        .w_enable     (w_enable),
        .w_data       (w_data),
        .rcving       (rcving),
        .r_error      (r_error)
`ifdef RX_BYTE_COUNT_EN
        ,
        .pkt_len      (pkt_len)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected byte.
    always @(negedge clk) begin
        if (n_rst && w_enable) begin
            chk("back_to_back_we", {7'd0, prev_we}, 8'h00);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 8'h01, 8'h00);
            end else begin
                chk("w_data", w_data, exp_q.pop_front());
            end
        end
        prev_we = w_enable;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_dedge();
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        step(1);
        eop = 1'b0;
        step(1);
    endtask

    task automatic send_bit(input logic b);
        shift_strobe = 1'b1;
        rx_bit = b;
        step(1);
        shift_strobe = 1'b0;
        step(7);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_wr);
        for (int i = 0; i < 8; i++) begin
            shift_strobe = 1'b1;
            rx_bit = b[i];
            if (i == 7 && exp_wr) exp_q.push_back(b);
            step(1);
            shift_strobe = 1'b0;
            if (i == 7) chk("we_latency", {7'd0, w_enable}, {7'd0, exp_wr});
            step(7);
        end
    endtask

    initial begin
        // Reset held while the line is active
        step(1);
        d_edge = 1'b1;
        step(1);
        d_edge = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        chk("rst_we", {7'd0, w_enable}, 8'h00);
        chk("rst_wdata", w_data, 8'h00);
        chk("rst_rcving", {7'd0, rcving}, 8'h00);
        chk("rst_rerror", {7'd0, r_error}, 8'h00);
        n_rst = 1'b1;
        step(2);
        chk("idle_rcving", {7'd0, rcving}, 8'h00);
        send_bit(1'b1);
        chk("idle_strobe_ignored", {7'd0, rcving}, 8'h00);

        // Good packet
        pulse_dedge();
        chk("good_rcving", {7'd0, rcving}, 8'h01);
        send_byte(8'h80, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        chk("wdata_hold", w_data, 8'h3C);
        pulse_eop();
        chk("good_end_rcving", {7'd0, rcving}, 8'h00);
        chk("good_end_rerror", {7'd0, r_error}, 8'h00);
        chk("good_q_empty", 8'(exp_q.size()), 8'h00);

        // Bad sync
        pulse_dedge();
        send_byte(8'h81, 1'b0);
        chk("badsync_rerror", {7'd0, r_error}, 8'h01);
        chk("badsync_rcving", {7'd0, rcving}, 8'h01);
        pulse_eop();
        chk("badsync_eop_rcving", {7'd0, rcving}, 8'h00);
        chk("badsync_eop_rerror", {7'd0, r_error}, 8'h01);
        pulse_dedge();
        chk("dedge_clears_rerror", {7'd0, r_error}, 8'h00);

        // Partial byte (packet already started by the d_edge above)
        send_byte(8'h80, 1'b0);
        send_byte(8'h11, 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        pulse_eop();
        chk("partial_rerror", {7'd0, r_error}, 8'h01);
        chk("partial_rcving", {7'd0, rcving}, 8'h00);

        // FIFO full on the first data byte
        pulse_dedge();
        send_byte(8'h80, 1'b0);
        fifo_full = 1'b1;
        send_byte(8'h5A, 1'b0);
        fifo_full = 1'b0;
        chk("full_rerror", {7'd0, r_error}, 8'h01);
        send_byte(8'hFF, 1'b0);
        chk("full_err_rcving", {7'd0, rcving}, 8'h01);
        pulse_eop();
        chk("full_eop_rcving", {7'd0, rcving}, 8'h00);

        // Overflow: third byte exceeds MAX_BYTES=2
        pulse_dedge();
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        chk("ovf_before_rerror", {7'd0, r_error}, 8'h00);
        send_byte(8'h03, 1'b0);
        chk("ovf_rerror", {7'd0, r_error}, 8'h01);
        pulse_eop();
`ifdef RX_BYTE_COUNT_EN
        chk("pkt_len", {1'b0, pkt_len}, 8'h02);
`endif

        // eop coincident with the 8th strobe of a data byte
        pulse_dedge();
        send_byte(8'h80, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        eop = 1'b1;
        shift_strobe = 1'b1;
        rx_bit = 1'b1;
        step(1);
        eop = 1'b0;
        shift_strobe = 1'b0;
        chk("coll_we", {7'd0, w_enable}, 8'h00);
        step(2);
        chk("coll_rerror", {7'd0, r_error}, 8'h01);
        chk("coll_rcving", {7'd0, rcving}, 8'h00);
        chk("coll_wdata_hold", w_data, 8'h02);

        // Reset mid-packet
        pulse_dedge();
        send_byte(8'h80, 1'b0);
        send_bit(1'b1);
        n_rst = 1'b0;
        #1;
        chk("midrst_rcving", {7'd0, rcving}, 8'h00);
        chk("midrst_wdata", w_data, 8'h00);
        chk("midrst_rerror", {7'd0, r_error}, 8'h00);
        step(1);
        n_rst = 1'b1;
        step(2);
        chk("final_q_empty", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
